// File: rtl/maxadcinit_pkg.sv
// Shared maxadc definitions: sequencer state encoding, SPI engine register map
// and the engine status decode.
package maxadcinit_pkg;

    typedef enum logic [2:0] {
        S_LOAD_HI = 3'd0,
        S_LOAD_LO = 3'd1,
        S_START   = 3'd2,
        S_SETTLE  = 3'd3,
        S_POLL    = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam logic [7:0] ADR_CTRL   = 8'h00;
    localparam logic [7:0] ADR_DAT_HI = 8'h02;
    localparam logic [7:0] ADR_DAT_LO = 8'h03;
    localparam logic [7:0] CTRL_START = 8'h01;
    localparam logic [1:0] BUSY_MASK  = 2'b11;

    function automatic logic engine_busy(input logic [1:0] status);
        return |(status & BUSY_MASK);
    endfunction

endpackage

// File: rtl/maxadcinit.sv
// Power-up register-table sequencer for the MAX19506 SPI engine; hands the
// engine's wishbone port to the host once the table has been replayed.
module maxadcinit
    import maxadcinit_pkg::*;
#(
    parameter int                      NUM_INIT   = 4,
    parameter logic [16*NUM_INIT-1:0]  INIT_TABLE = {NUM_INIT{16'h0000}}
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       rerun,
    output logic       m_stb_o,
    output logic       m_cyc_o,
    output logic       m_we_o,
    output logic [7:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    output logic       init_done
);

    state_e      state_r;
    logic [3:0]  idx_r;
    logic        init_done_r;

    logic [15:0] entry_s;
    logic        seq_wr_s;
    logic [7:0]  seq_adr_s;
    logic [7:0]  seq_dat_s;
    logic        last_s;
    logic        unused_s;

    // Upper status bits carry nothing the sequencer needs.
    assign unused_s  = ^m_dat_i[7:2];
    assign wb_ack_o  = 1'b1;
    assign init_done = init_done_r;
    assign last_s    = (idx_r == 4'(NUM_INIT - 1));

    // Select the current table entry.
    always_comb begin
        entry_s = INIT_TABLE[32'd16 * 32'(idx_r) +: 16];
    end

    // Decode the sequencer's bus cycle from the current state.
    always_comb begin
        seq_wr_s  = 1'b0;
        seq_adr_s = 8'h00;
        seq_dat_s = 8'h00;
        case (state_r)
            S_LOAD_HI: begin
                seq_wr_s  = 1'b1;
                seq_adr_s = ADR_DAT_HI;
                seq_dat_s = entry_s[15:8];
            end
            S_LOAD_LO: begin
                seq_wr_s  = 1'b1;
                seq_adr_s = ADR_DAT_LO;
                seq_dat_s = entry_s[7:0];
            end
            S_START: begin
                seq_wr_s  = 1'b1;
                seq_adr_s = ADR_CTRL;
                seq_dat_s = CTRL_START;
            end
            default: begin
                seq_wr_s  = 1'b0;
                seq_adr_s = 8'h00;
                seq_dat_s = 8'h00;
            end
        endcase
    end

    // Engine-side mux: host passes straight through once done; nothing drives during reset.
    always_comb begin
        m_stb_o = 1'b0;
        m_cyc_o = 1'b0;
        m_we_o  = 1'b0;
        m_adr_o = 8'h00;
        m_dat_o = 8'h00;
        if (rst) begin
            m_stb_o = 1'b0;
            m_cyc_o = 1'b0;
            m_we_o  = 1'b0;
            m_adr_o = 8'h00;
            m_dat_o = 8'h00;
        end else if (state_r == S_DONE) begin
            m_stb_o = wb_stb_i;
            m_cyc_o = wb_cyc_i;
            m_we_o  = wb_we_i;
            m_adr_o = wb_adr_i;
            m_dat_o = wb_dat_i;
        end else begin
            m_stb_o = seq_wr_s;
            m_cyc_o = seq_wr_s;
            m_we_o  = seq_wr_s;
            m_adr_o = seq_adr_s;
            m_dat_o = seq_dat_s;
        end
    end

    // Host read-back: bit 7 flags the sequencer as still owning the engine.
    always_comb begin
        if (state_r == S_DONE) begin
            wb_dat_o = {1'b0, 5'b00000, m_dat_i[1:0]};
        end else begin
            wb_dat_o = {1'b1, 3'b000, idx_r};
        end
    end

    // Sequencer FSM; no poll timeout, a stuck engine simply holds it in S_POLL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_LOAD_HI;
            idx_r       <= 4'd0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                S_LOAD_HI: state_r <= S_LOAD_LO;
                S_LOAD_LO: state_r <= S_START;
                S_START:   state_r <= S_SETTLE;
                S_SETTLE:  state_r <= S_POLL;
                S_POLL: begin
                    if (engine_busy(m_dat_i[1:0])) begin
                        state_r <= S_POLL;
                    end else if (last_s) begin
                        state_r     <= S_DONE;
                        init_done_r <= 1'b1;
                    end else begin
                        idx_r   <= idx_r + 4'd1;
                        state_r <= S_LOAD_HI;
                    end
                end
                S_DONE: begin
                    if (rerun) begin
                        idx_r       <= 4'd0;
                        state_r     <= S_LOAD_HI;
                        init_done_r <= 1'b0;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r     <= S_LOAD_HI;
                    idx_r       <= 4'd0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxadcinit.sv
// Directed bench for maxadcinit with a behavioural SPI engine and a bus-write
// scoreboard.
module tb_maxadcinit;

    localparam int          NUM_INIT = 2;
    localparam logic [31:0] TABLE    = {16'h8A5C, 16'h0123};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
    logic [7:0] wb_adr_i = 8'h00, wb_dat_i = 8'h00;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       rerun = 1'b0;
    logic       m_stb_o, m_cyc_o, m_we_o;
    logic [7:0] m_adr_o, m_dat_o;
    logic [7:0] m_dat_i;
    logic       init_done;

    maxadcinit #(.NUM_INIT(NUM_INIT), .INIT_TABLE(TABLE)) dut (
        .clk(clk), .rst(rst),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .rerun(rerun),
        .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Engine model: no reset, start ignored while a frame is running.
    int   busy_len = 40;
    int   eng_cnt  = 0;
    logic stuck    = 1'b0;
    always @(posedge clk) begin
        if (m_stb_o && m_cyc_o && m_we_o && m_adr_o == 8'h00 && m_dat_o[0] && eng_cnt == 0)
            eng_cnt <= busy_len;
        else if (eng_cnt != 0)
            eng_cnt <= eng_cnt - 1;
    end
    assign m_dat_i = (stuck || eng_cnt != 0) ? 8'h01 : 8'h00;

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic [15:0] e);
        exp_q.push_back({8'h02, e[15:8]});
        exp_q.push_back({8'h03, e[7:0]});
        exp_q.push_back({8'h00, 8'h01});
    endtask

    task automatic host_set(input logic wr, input logic [7:0] adr, input logic [7:0] dat);
        wb_stb_i = wr;
        wb_cyc_i = wr;
        wb_we_i  = wr;
        wb_adr_i = adr;
        wb_dat_i = dat;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (init_done !== 1'b1 && n < limit) begin
            @(posedge clk); #3;
            n++;
        end
        check("done_timeout", {31'd0, init_done}, 32'd1);
    endtask

    // Every write cycle on the engine bus must match the next expected write.
    always @(negedge clk) begin
        if (m_stb_o && m_cyc_o && m_we_o) begin
            check("sb_write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0)
                check("bus_write", {16'd0, m_adr_o, m_dat_o}, {16'd0, exp_q.pop_front()});
        end
    end

    initial begin
        int   cyc, falls, done_cyc, w, n, idle_cyc, wr_cyc;
        logic prev_busy;

        // Reset
        #2;
        check("rst_m_strobes", {29'd0, m_stb_o, m_cyc_o, m_we_o}, 32'd0);
        @(posedge clk); #3;
        check("rst_wb_dat_o", {24'd0, wb_dat_o}, 32'h80);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_wb_ack", {31'd0, wb_ack_o}, 32'd1);

        // Power-up replay, with a dropped host write and an ignored rerun
        push_entry(16'h0123);
        push_entry(16'h8A5C);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        cyc = 1; falls = 0; done_cyc = 0; prev_busy = 1'b0;
        while (cyc < 400) begin
            if (cyc == 10) check("seq_wb_dat_o_idx0", {24'd0, wb_dat_o}, 32'h80);
            if (cyc == 11) check("seq_host_dropped", {31'd0, m_stb_o}, 32'd0);
            if (cyc == 60) check("seq_wb_dat_o_idx1", {24'd0, wb_dat_o}, 32'h81);
            if (prev_busy && m_dat_i[1:0] == 2'b00) falls++;
            if (falls == 2 && done_cyc == 0) begin
                check("done_low_at_idle", {31'd0, init_done}, 32'd0);
                done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                check("done_high_after_idle", {31'd0, init_done}, 32'd1);
                break;
            end
            prev_busy = (m_dat_i[1:0] != 2'b00);
            @(posedge clk); #1;
            cyc++;
            if (cyc >= 10 && cyc <= 12) host_set(1'b1, 8'h02, 8'hAA);
            else host_set(1'b0, 8'h00, 8'h00);
            rerun = (cyc == 20);
            #2;
        end
        check("done_cycle", done_cyc, 32'd88);
        check("sb_empty_boot", exp_q.size(), 32'd0);

        // Host pass-through
        @(posedge clk); #1;
        exp_q.push_back({8'h03, 8'h55});
        host_set(1'b1, 8'h03, 8'h55);
        #2;
        check("pt_m_stb", {31'd0, m_stb_o}, 32'd1);
        check("pt_m_adr", {24'd0, m_adr_o}, 32'h03);
        check("pt_m_dat", {24'd0, m_dat_o}, 32'h55);
        check("pt_wb_dat_o_idle", {24'd0, wb_dat_o}, 32'h00);
        @(posedge clk); #1;
        exp_q.push_back({8'h00, 8'h01});
        host_set(1'b1, 8'h00, 8'h01);
        #2;
        @(posedge clk); #1;
        host_set(1'b0, 8'h00, 8'h00);
        #2;
        check("pt_wb_dat_o_busy", {24'd0, wb_dat_o}, 32'h01);
        w = 0;
        while (m_dat_i[1:0] != 2'b00 && w < 100) begin
            @(posedge clk); #3;
            w++;
        end
        check("engine_idle_wait", {30'd0, m_dat_i[1:0]}, 32'd0);

        // rerun together with a host write
        @(posedge clk); #1;
        exp_q.push_back({8'h03, 8'h77});
        push_entry(16'h0123);
        push_entry(16'h8A5C);
        rerun = 1'b1;
        host_set(1'b1, 8'h03, 8'h77);
        #2;
        check("rerun_host_fwd", {31'd0, m_stb_o}, 32'd1);
        @(posedge clk); #1;
        rerun = 1'b0;
        host_set(1'b0, 8'h00, 8'h00);
        #2;
        check("rerun_done_low", {31'd0, init_done}, 32'd0);
        check("rerun_wb_dat_o", {24'd0, wb_dat_o}, 32'h80);
        wait_done(300);
        check("sb_empty_rerun", exp_q.size(), 32'd0);

        // rst mid-poll with the engine busy
        busy_len = 200;
        @(posedge clk); #1;
        push_entry(16'h0123);
        rerun = 1'b1;
        @(posedge clk); #1;
        rerun = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst_m_stb", {31'd0, m_stb_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        busy_len = 40;
        push_entry(16'h0123);
        push_entry(16'h8A5C);
        #2;
        check("midrst_wb_dat_o", {24'd0, wb_dat_o}, 32'h80);
        check("midrst_init_done", {31'd0, init_done}, 32'd0);
        n = 1; idle_cyc = 0; wr_cyc = 0;
        while (n < 400 && wr_cyc == 0) begin
            if (idle_cyc == 0 && m_dat_i[1:0] == 2'b00) idle_cyc = n;
            if (m_stb_o && m_we_o && m_adr_o == 8'h02 && m_dat_o == 8'h8A) wr_cyc = n;
            if (wr_cyc == 0) begin
                @(posedge clk); #3;
                n++;
            end
        end
        check("midrst_waits_residual", {31'd0, idle_cyc > 100}, 32'd1);
        check("midrst_reload_after_idle", wr_cyc, idle_cyc + 1);
        wait_done(300);
        check("sb_empty_midrst", exp_q.size(), 32'd0);

        // Engine busy stuck: sequencer parks in S_POLL
        stuck = 1'b1;
        @(posedge clk); #1;
        push_entry(16'h0123);
        rerun = 1'b1;
        @(posedge clk); #1;
        rerun = 1'b0;
        repeat (1000) @(posedge clk);
        #3;
        check("stuck_wb_dat_o", {24'd0, wb_dat_o}, 32'h80);
        check("stuck_init_done", {31'd0, init_done}, 32'd0);
        check("stuck_no_strobe", {31'd0, m_stb_o}, 32'd0);
        check("stuck_sb_drained", exp_q.size(), 32'd0);
        push_entry(16'h8A5C);
        stuck = 1'b0;
        wait_done(300);
        check("sb_empty_final", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
